bch_syndrome_sequencer: RTL and testbench

- Control front end for a bank of per-syndrome accumulators (dsynN-style units sharing `start`, `start_pipelined`, `ce` and `data_pipelined`).
- Accepts a codeword as a valid/ready stream of BITS-wide beats and counts beats up to ceil(N/BITS).
- Generates the start, pipelined-start and clock-enable strobes, and delays data to match the unit pipeline depth.
- Flushes the pipeline after the last beat and holds the finished syndromes until the downstream error locator acknowledges them.

---
 rtl/bch_syn_seq_pkg.sv | 25 ++
 rtl/bch_syn_seq_delay.sv | 44 ++++
 rtl/bch_syndrome_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_bch_syndrome_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bch_syn_seq_pkg.sv
// Shared definitions for the BCH syndrome sequencer: FSM state encoding,
// beats-per-codeword arithmetic and counter sizing.
package bch_syn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Width of the drain counter; it never holds more than the pipeline depth (2).
  localparam int DRAIN_W = 2;

  // Number of BITS-wide beats needed to carry an N-bit codeword.
  function automatic int calc_beats(input int n, input int bits);
    return (n + bits - 1) / bits;
  endfunction

  // Beat counter width: it counts up to BEATS inclusive (held through DRAIN/HOLD).
  function automatic int cnt_width(input int beats);
    return (beats < 1) ? 1 : $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/bch_syn_seq_delay.sv
// Clock-enable qualified delay line of depth 0 (wire) or 1 (register).
// A synchronous clear empties the register when a codeword is abandoned.
module bch_syn_seq_delay
  import bch_syn_seq_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl_s;
      assign unused_ctrl_s = ^{clk, reset, ce, clear};
      assign q = d;
    end else if (DEPTH == 1) begin : g_reg
      logic [WIDTH-1:0] q_r;

      // Advance the delay stage only when the syndrome units advance.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_r <= {WIDTH{1'b0}};
        end else if (clear) begin
          q_r <= {WIDTH{1'b0}};
        end else if (ce) begin
          q_r <= d;
        end else begin
          q_r <= q_r;
        end
      end

      assign q = q_r;
    end else begin : g_bad_depth
      $error("bch_syn_seq_delay: DEPTH must be 0 or 1");
    end
  endgenerate

endmodule

// File: rtl/bch_syndrome_sequencer.sv
// Control front end for a bank of per-syndrome accumulators: accepts a
// codeword as a valid/ready beat stream, drives start / start_pipelined /
// ce / data_pipelined, flushes the unit pipeline and holds the result
// until the error locator acknowledges it.
// Optional feature macro: BCH_SYN_SEQ_ABORT_EN adds an `abort` input.
module bch_syndrome_sequencer
  import bch_syn_seq_pkg::*;
#(
  parameter int N               = 255,
  parameter int BITS            = 8,
  parameter int PIPELINE_STAGES = 0
) (
  input  logic            clk,
  input  logic            reset,
`ifdef BCH_SYN_SEQ_ABORT_EN
  input  logic            abort,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  input  logic            in_last,
  output logic            syn_start,
  output logic            syn_start_pipelined,
  output logic            syn_ce,
  output logic [BITS-1:0] syn_data,
  output logic            syn_valid,
  input  logic            syn_ack,
  output logic            len_err
);

  localparam int                 BEATS      = calc_beats(N, BITS);
  localparam int                 CW         = cnt_width(BEATS);
  localparam logic [CW-1:0]      LAST_CNT   = CW'(BEATS - 1);
  localparam logic [CW-1:0]      CNT_ONE    = CW'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPELINE_STAGES);
  localparam int                 DLY        = (PIPELINE_STAGES == 2) ? 1 : 0;

  generate
    if (PIPELINE_STAGES < 0 || PIPELINE_STAGES > 2) begin : g_bad_stages
      $error("bch_syndrome_sequencer: PIPELINE_STAGES must be 0..2");
    end
    if (N < BITS) begin : g_bad_len
      $error("bch_syndrome_sequencer: N must be >= BITS");
    end
  endgenerate

  state_t               state_r, state_nx;
  logic [CW-1:0]        count_r, count_nx;
  logic [DRAIN_W-1:0]   drain_r, drain_nx;
  logic                 in_ready_r;
  logic                 syn_valid_r;
  logic                 len_err_r;

  logic                 abort_kill_s;
  logic                 hold_release_s;
  logic                 beat_s;
  logic                 drain_ce_s;
  logic                 len_bad_s;
  logic [BITS-1:0]      data_in_s;
  logic [BITS-1:0]      data_dly_s;
  logic                 start_dly_s;

`ifdef BCH_SYN_SEQ_ABORT_EN
  // Abort only cancels a codeword in flight; in HOLD it acts as an acknowledge.
  assign abort_kill_s   = abort && ((state_r == ACCUM) || (state_r == DRAIN));
  assign hold_release_s = syn_ack || abort;
`else
  assign abort_kill_s   = 1'b0;
  assign hold_release_s = syn_ack;
`endif

  // An aborted cycle drops any beat offered alongside it.
  assign beat_s     = in_valid && in_ready_r && !abort_kill_s;
  assign drain_ce_s = (state_r == DRAIN) && !abort_kill_s;
  assign syn_ce     = beat_s || drain_ce_s;
  assign syn_start  = beat_s && (count_r == {CW{1'b0}});

  // in_last must coincide exactly with the counter's final beat.
  assign len_bad_s  = beat_s && ((count_r == LAST_CNT) ? !in_last : in_last);

  // Flush cycles feed zeros into the units.
  assign data_in_s  = (state_r == DRAIN) ? {BITS{1'b0}} : in_data;

  // Next-state, beat counter and drain counter.
  always_comb begin
    state_nx = state_r;
    count_nx = count_r;
    drain_nx = drain_r;
    case (state_r)
      IDLE, ACCUM: begin
        if (abort_kill_s) begin
          state_nx = IDLE;
          count_nx = {CW{1'b0}};
          drain_nx = {DRAIN_W{1'b0}};
        end else if (beat_s) begin
          count_nx = count_r + CNT_ONE;
          if (count_r == LAST_CNT) begin
            if (DRAIN_INIT != {DRAIN_W{1'b0}}) begin
              state_nx = DRAIN;
              drain_nx = DRAIN_INIT;
            end else begin
              state_nx = HOLD;
            end
          end else begin
            state_nx = ACCUM;
          end
        end else begin
          state_nx = state_r;
        end
      end
      DRAIN: begin
        if (abort_kill_s) begin
          state_nx = IDLE;
          count_nx = {CW{1'b0}};
          drain_nx = {DRAIN_W{1'b0}};
        end else begin
          drain_nx = drain_r - DRAIN_W'(1);
          if (drain_r == DRAIN_W'(1)) begin
            state_nx = HOLD;
          end else begin
            state_nx = DRAIN;
          end
        end
      end
      HOLD: begin
        if (hold_release_s) begin
          state_nx = IDLE;
          count_nx = {CW{1'b0}};
        end else begin
          state_nx = HOLD;
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = {CW{1'b0}};
        drain_nx = {DRAIN_W{1'b0}};
      end
    endcase
  end

  // State registers plus registered ready/valid/length-error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      count_r     <= {CW{1'b0}};
      drain_r     <= {DRAIN_W{1'b0}};
      in_ready_r  <= 1'b0;
      syn_valid_r <= 1'b0;
      len_err_r   <= 1'b0;
    end else begin
      state_r     <= state_nx;
      count_r     <= count_nx;
      drain_r     <= drain_nx;
      in_ready_r  <= (state_nx == IDLE) || (state_nx == ACCUM);
      syn_valid_r <= (state_nx == HOLD);
      len_err_r   <= len_err_r || len_bad_s;
    end
  end

  bch_syn_seq_delay #(.WIDTH(1), .DEPTH(DLY)) u_start_dly (
    .clk   (clk),
    .reset (reset),
    .ce    (syn_ce),
    .clear (abort_kill_s),
    .d     (syn_start),
    .q     (start_dly_s)
  );

  bch_syn_seq_delay #(.WIDTH(BITS), .DEPTH(DLY)) u_data_dly (
    .clk   (clk),
    .reset (reset),
    .ce    (syn_ce),
    .clear (abort_kill_s),
    .d     (data_in_s),
    .q     (data_dly_s)
  );

  assign syn_start_pipelined = start_dly_s;
  assign syn_data            = (state_r == DRAIN) ? {BITS{1'b0}} : data_dly_s;
  assign in_ready            = in_ready_r;
  assign syn_valid           = syn_valid_r;
  assign len_err             = len_err_r;

endmodule

// File: tb/tb_bch_syndrome_sequencer.sv
// Self-checking bench for bch_syndrome_sequencer. Four configurations run in
// parallel, each with directed frames, an async reset pulse and a long
// randomized stretch, all checked every cycle against a timestamp-based
// behavioural model. Optional: BCH_SYN_SEQ_ABORT_EN.
module tb_bch_syndrome_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit stim_done [4];

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", g, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int CN = (g == 0) ? 15 : (g == 1) ? 255 : (g == 2) ? 21 : 8;
    localparam int CB = (g == 0) ? 1  : 8;
    localparam int CP = (g == 0) ? 0  : (g == 1) ? 2 : (g == 2) ? 1 : 2;
    localparam int BEATS = (CN + CB - 1) / CB;
    // Hand-computed: first syn_start to syn_valid, and syn_ce count, for a
    // back-to-back frame = BEATS + PIPELINE_STAGES (15, 32+2, 3+1, 1+2).
    localparam int EXP_LAT = (g == 0) ? 15 : (g == 1) ? 34 : (g == 2) ? 4 : 3;

    logic          rst, iv, il, ack, ab;
    logic [CB-1:0] id;
    logic          rdy, st, stp, ce, vld, lerr_o;
    logic [CB-1:0] sd;

    // Model state
    int            k = 0;
    bit            done = 1'b0;
    int            c = 0;
    int            lastc = 0;
    bit            fresh = 1'b1;
    bit            lerr = 1'b0;
    bit            pst = 1'b0;
    logic [CB-1:0] pd = '0;
    int            t_start = -1;
    int            ce_cnt = 0;
    bit            lit_done = 1'b0;

    bch_syndrome_sequencer #(.N(CN), .BITS(CB), .PIPELINE_STAGES(CP)) dut (
      .clk                 (clk),
      .reset               (rst),
`ifdef BCH_SYN_SEQ_ABORT_EN
      .abort               (ab),
`endif
      .in_valid            (iv),
      .in_ready            (rdy),
      .in_data             (id),
      .in_last             (il),
      .syn_start           (st),
      .syn_start_pipelined (stp),
      .syn_ce              (ce),
      .syn_data            (sd),
      .syn_valid           (vld),
      .syn_ack             (ack),
      .len_err             (lerr_o)
    );

    initial begin : stim
      rst = 1'b1; iv = 1'b0; id = '0; il = 1'b0; ack = 1'b0; ab = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      // Frame A: back-to-back beats, then acknowledge withheld for 11 cycles.
      for (int i = 0; i < BEATS; i++) begin
        iv = 1'b1; id = CB'($urandom); il = (i == BEATS - 1);
        @(posedge clk); #1;
      end
      iv = 1'b0; il = 1'b0;
      repeat (CP + 11) begin @(posedge clk); #1; end
      ack = 1'b1; iv = 1'b1; id = CB'($urandom);
      @(posedge clk); #1;
      // Frame B: in_last early (or missing when BEATS == 1).
      for (int i = 0; i < BEATS + CP + 3; i++) begin
        iv = 1'b1; id = CB'($urandom);
        il = (BEATS >= 2) ? (k == BEATS - 2) : 1'b0;
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk("len_err_after_bad_last", g, 32'(lerr_o), 32'd1);
      @(posedge clk); #1;
      // Stream correctly framed beats, then an asynchronous reset mid-frame.
      for (int i = 0; i < 12; i++) begin
        iv = 1'b1; id = CB'($urandom); il = (k == BEATS - 1); ack = 1'b1;
        @(posedge clk); #1;
      end
      #1 rst = 1'b1; iv = 1'b0; id = '0; il = 1'b0; ack = 1'b0; ab = 1'b0;
      #2;
      chk("rst_in_ready", g, 32'(rdy), 32'd0);
      chk("rst_syn_valid", g, 32'(vld), 32'd0);
      chk("rst_len_err", g, 32'(lerr_o), 32'd0);
      chk("rst_syn_ce", g, 32'(ce), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
        iv  = ($urandom_range(0, 99) < 50);
        id  = CB'($urandom);
        il  = (k == BEATS - 1) ^ ($urandom_range(0, 99) < 3);
        ack = ($urandom_range(0, 99) < 30);
`ifdef BCH_SYN_SEQ_ABORT_EN
        ab  = ($urandom_range(0, 99) < 3);
`endif
        @(posedge clk); #1;
      end
      iv = 1'b0; ack = 1'b1; ab = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      stim_done[g] = 1'b1;
    end

    initial begin : cmp
      bit drain_e, hold_e, rdy_e, akill, acc, ce_e, st_e;
      while (!stim_done[g]) begin
        @(negedge clk);
        if (rst) begin
          chk("reset_in_ready", g, 32'(rdy), 32'd0);
          chk("reset_syn_start", g, 32'(st), 32'd0);
          chk("reset_syn_start_p", g, 32'(stp), 32'd0);
          chk("reset_syn_ce", g, 32'(ce), 32'd0);
          chk("reset_syn_valid", g, 32'(vld), 32'd0);
          chk("reset_len_err", g, 32'(lerr_o), 32'd0);
          chk("reset_syn_data", g, 32'(sd), 32'd0);
          k = 0; done = 1'b0; lerr = 1'b0; pst = 1'b0; pd = '0; fresh = 1'b1;
        end else begin
          drain_e = done && ((c - lastc) <= CP);
          hold_e  = done && ((c - lastc) > CP);
          rdy_e   = !done && !fresh;
          akill   = ab && ((!done && k > 0) || drain_e);
          acc     = iv && rdy_e && !akill;
          ce_e    = acc || (drain_e && !akill);
          st_e    = acc && (k == 0);
          chk("in_ready", g, 32'(rdy), 32'(rdy_e));
          chk("syn_ce", g, 32'(ce), 32'(ce_e));
          chk("syn_start", g, 32'(st), 32'(st_e));
          chk("syn_valid", g, 32'(vld), 32'(hold_e));
          chk("len_err", g, 32'(lerr_o), 32'(lerr));
          if (CP < 2) begin
            chk("syn_start_pipelined", g, 32'(stp), 32'(st_e));
            if (ce_e) chk("syn_data", g, 32'(sd), drain_e ? 32'd0 : 32'(id));
          end else if (ce_e) begin
            chk("syn_start_pipelined", g, 32'(stp), 32'(pst));
            chk("syn_data", g, 32'(sd), drain_e ? 32'd0 : 32'(pd));
          end
          // Literal pins on the first frame after power-up.
          if (!lit_done) begin
            if (vld && t_start >= 0) begin
              chk("first_valid_latency", g, 32'(c - t_start), 32'(EXP_LAT));
              chk("first_frame_ce_count", g, 32'(ce_cnt), 32'(EXP_LAT));
              lit_done = 1'b1;
            end else begin
              if (st && t_start < 0) t_start = c;
              if (ce && t_start >= 0) ce_cnt++;
            end
          end
          // Effect of the coming clock edge.
          if (akill) begin
            k = 0; done = 1'b0; pst = 1'b0; pd = '0;
          end else begin
            if (ce_e) begin
              pst = st_e;
              pd  = acc ? id : '0;
            end
            if (hold_e && (ack || ab)) begin
              done = 1'b0;
            end else if (acc) begin
              if ((k == BEATS - 1) ? !il : il) lerr = 1'b1;
              k++;
              if (k == BEATS) begin
                k = 0; done = 1'b1; lastc = c;
              end
            end
          end
          fresh = 1'b0;
        end
        c++;
      end
      if (!lit_done) chk("first_valid_seen", g, 32'd0, 32'd1);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : summary
    wait (stim_done[0] && stim_done[1] && stim_done[2] && stim_done[3]);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
